fifo_wr_arbiter: RTL and testbench

Write-side controller for the dual-clock FIFO memory. It shares the single FIFO write port between N_REQ on-chip requesters, such as the register file, the ALU result path and the system controller. It also owns the write pointer, the Gray-coded pointer handed to the read domain, and the full flag. Everything runs in the write clock domain. The read pointer arrives already synchronized.

---
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Write-side controller for the dual-clock FIFO. It shares the single memory
// write port between N_REQ requesters. It also owns the binary write pointer,
// the Gray write pointer exported to the read domain, and the full flag.
// Everything runs on WCLK. The read pointer arrives already synchronized.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  FIFO depth in words (power of 2, >= 4); A = $clog2(DEPTH)
//   N_REQ  number of requesters (2..4)
//
// Ports
//   WCLK            write-domain clock
//   WRST            asynchronous active-low reset
//   arb_mode        0 = round-robin, 1 = fixed priority (index 0 highest)
//   req_valid       per-requester write request
//   req_data        requester i data in bits [i*WIDTH +: WIDTH]
//   req_ready       one-hot grant (combinational); transfer = valid & ready
//   rptr_gray_sync  read pointer, Gray-coded, synchronized into WCLK
//   wdata           data to the memory write port (registered)
//   waddr           memory write address (registered)
//   wclk_en         memory write enable, one cycle per transfer (registered)
//   wptr_gray       Gray write pointer for the read-domain synchronizer
//   full            FIFO full (registered)
//   grant_id        index of the requester whose write is issued
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int N_REQ = 2,
    localparam int A    = $clog2(DEPTH),
    localparam int GW   = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
    input  logic                   WCLK,
    input  logic                   WRST,
    input  logic                   arb_mode,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [A:0]             rptr_gray_sync,
    output logic [WIDTH-1:0]       wdata,
    output logic [A-1:0]           waddr,
    output logic                   wclk_en,
    output logic [A:0]             wptr_gray,
    output logic                   full,
    output logic [GW-1:0]          grant_id
);

    // Binary to Gray conversion of a pointer.
    function automatic logic [A:0] bin2gray(input logic [A:0] b);
        return b ^ (b >> 1);
    endfunction

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: the two Gray MSBs are inverted and the remaining bits match.
    function automatic logic is_full(input logic [A:0] wg, input logic [A:0] rg);
        return (wg[A:A-1] == ~rg[A:A-1]) && (wg[A-2:0] == rg[A-2:0]);
    endfunction

    logic [A:0]    wptr_bin_p1;   // binary write pointer, one lap bit above the address
    logic [GW-1:0] rr_last_p1;    // last granted requester, drives round-robin fairness

    logic [A:0]    wptr_bin_nxt;
    logic [A:0]    wptr_gray_nxt;
    logic [GW-1:0] gnt_idx;
    logic          gnt_found;
    logic          xfer;

    // ---- Stage p0: combinational arbitration -------------------------------
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        if (arb_mode) begin
            // Fixed priority: descending scan so the lowest valid index wins.
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    gnt_idx   = GW'(i);
                    gnt_found = 1'b1;
                end
            end
        end else begin
            // Round-robin: start one past the last winner and wrap.
            for (int k = 1; k <= N_REQ; k++) begin
                if (!gnt_found && req_valid[(int'(rr_last_p1) + k) % N_REQ]) begin
                    gnt_idx   = GW'((int'(rr_last_p1) + k) % N_REQ);
                    gnt_found = 1'b1;
                end
            end
        end
    end

    // Grant is withheld while full and while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (gnt_found && !full && WRST)
            req_ready[gnt_idx] = 1'b1;
    end

    assign xfer          = |(req_ready & req_valid);
    assign wptr_bin_nxt  = wptr_bin_p1 + 1'b1;
    assign wptr_gray_nxt = bin2gray(wptr_bin_nxt);

    // ---- Stage p1: registered write port, pointers and full flag -----------
    always_ff @(posedge WCLK or negedge WRST) begin
        if (!WRST) begin
            wdata       <= '0;
            waddr       <= '0;
            wclk_en     <= 1'b0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            grant_id    <= '0;
            wptr_bin_p1 <= '0;
            rr_last_p1  <= GW'(N_REQ - 1);
        end else begin
            wclk_en <= xfer;
            if (xfer) begin
                wdata       <= req_data[int'(gnt_idx) * WIDTH +: WIDTH];
                waddr       <= wptr_bin_p1[A-1:0];
                grant_id    <= gnt_idx;
                rr_last_p1  <= gnt_idx;
                wptr_bin_p1 <= wptr_bin_nxt;
                wptr_gray   <= wptr_gray_nxt;
                // The write that fills the last slot raises full on its own edge.
                full        <= is_full(wptr_gray_nxt, rptr_gray_sync);
            end else begin
                // Re-evaluated every idle cycle so full drops once the reader moves.
                full        <= is_full(wptr_gray, rptr_gray_sync);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (WIDTH=8, DEPTH=16, N_REQ=2). Inputs are
// driven 1 time unit after the rising edge; registered outputs are sampled at
// that point and combinational req_ready one unit later.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int N_REQ = 2;
    localparam int A     = 4;

    logic             WCLK;
    logic             WRST;
    logic             arb_mode;
    logic [1:0]       req_valid;
    logic [15:0]      req_data;
    logic [1:0]       req_ready;
    logic [A:0]       rptr_gray_sync;
    logic [7:0]       wdata;
    logic [A-1:0]     waddr;
    logic             wclk_en;
    logic [A:0]       wptr_gray;
    logic             full;
    logic [0:0]       grant_id;

    int tests_run;
    int tests_failed;
    int n_wr;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) dut (
        .WCLK           (WCLK),
        .WRST           (WRST),
        .arb_mode       (arb_mode),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rptr_gray_sync (rptr_gray_sync),
        .wdata          (wdata),
        .waddr          (waddr),
        .wclk_en        (wclk_en),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .grant_id       (grant_id)
    );

    initial WCLK = 1'b0;
    always #5 WCLK = ~WCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge WCLK);
        #1;
    endtask

    // Synchronous-looking reset pulse; release lands between edges.
    task automatic do_reset();
        WRST           = 1'b0;
        req_valid      = 2'b00;
        rptr_gray_sync = '0;
        tick();
        WRST = 1'b1;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        WRST           = 1'b0;
        arb_mode       = 1'b0;
        req_valid      = 2'b11;
        req_data       = 16'h0000;
        rptr_gray_sync = '0;

        // ---- Reset state ----------------------------------------------------
        tick();
        chk("rst_wclk_en",   wclk_en,   0);
        chk("rst_full",      full,      0);
        chk("rst_wptr_gray", wptr_gray, 0);
        chk("rst_waddr",     waddr,     0);
        chk("rst_wdata",     wdata,     0);
        chk("rst_grant_id",  grant_id,  0);
        chk("rst_req_ready", req_ready, 0);

        // ---- 1: single write from requester 0 ------------------------------
        WRST      = 1'b1;
        req_valid = 2'b01;
        req_data  = 16'h00A5;
        #1;
        chk("t1_ready", req_ready, 2'b01);
        tick();
        chk("t1_wclk_en",   wclk_en,   1);
        chk("t1_waddr",     waddr,     0);
        chk("t1_wdata",     wdata,     8'hA5);
        chk("t1_grant_id",  grant_id,  0);
        chk("t1_wptr_gray", wptr_gray, 5'b00001);

        // ---- 2: round-robin alternation ------------------------------------
        do_reset();
        arb_mode  = 1'b0;
        req_valid = 2'b11;
        req_data  = 16'h2211;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("t2_grant", grant_id, i % 2);
            chk("t2_waddr", waddr,    i);
            chk("t2_wdata", wdata,    (i % 2 == 0) ? 8'h11 : 8'h22);
            chk("t2_en",    wclk_en,  1);
        end
        req_valid = 2'b00;
        tick();
        chk("t2_idle_en",    wclk_en,  0);
        chk("t2_idle_waddr", waddr,    3);
        chk("t2_idle_wdata", wdata,    8'h22);
        chk("t2_idle_grant", grant_id, 1);

        // ---- 3: fixed priority ---------------------------------------------
        arb_mode  = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_ready", req_ready, 2'b01);
            tick();
            chk("t3_grant", grant_id, 0);
            chk("t3_waddr", waddr,    4 + i);
            chk("t3_wdata", wdata,    8'h11);
        end
        arb_mode  = 1'b0;
        req_valid = 2'b00;

        // ---- 4: fill to full, block, then drain one slot -------------------
        do_reset();
        req_valid = 2'b01;
        for (int i = 0; i < 16; i++) begin
            req_data = 16'(8'h30 + i);
            #1;
            chk("t4_ready", req_ready, 2'b01);
            tick();
            chk("t4_en",    wclk_en, 1);
            chk("t4_waddr", waddr,   i);
            chk("t4_full",  full,    (i == 15) ? 1 : 0);
        end
        chk("t4_wptr_gray", wptr_gray, 5'b11000);
        chk("t4_wdata",     wdata,     8'h3F);
        #1;
        chk("t4_blocked_ready", req_ready, 2'b00);
        tick();
        chk("t4_blocked_en",   wclk_en, 0);
        chk("t4_blocked_full", full,    1);
        rptr_gray_sync = 5'b00001;
        tick();
        chk("t4_drain_full", full,    0);
        chk("t4_drain_en",   wclk_en, 0);
        req_data = 16'h0077;
        #1;
        chk("t4_resume_ready", req_ready, 2'b01);
        tick();
        chk("t4_resume_en",    wclk_en, 1);
        chk("t4_resume_waddr", waddr,   0);
        chk("t4_resume_wdata", wdata,   8'h77);
        chk("t4_refull",       full,    1);

        // ---- 5: wrap-around with the reader keeping pace --------------------
        do_reset();
        req_valid = 2'b01;
        n_wr      = 0;
        for (int i = 0; i < 20; i++) begin
            req_data = 16'(i);
            tick();
            chk("t5_waddr", waddr,   i % 16);
            chk("t5_full",  full,    0);
            chk("t5_en",    wclk_en, 1);
            n_wr++;
            rptr_gray_sync = 5'(n_wr ^ (n_wr >> 1));
            if (i == 15)
                chk("t5_gray16", wptr_gray, 5'b11000);
        end
        chk("t5_gray20", wptr_gray, 5'b11110);

        // ---- 6: asynchronous reset mid-burst -------------------------------
        req_valid = 2'b11;
        req_data  = 16'h2211;
        tick();
        tick();
        #2;
        WRST = 1'b0;
        #1;
        chk("t6_rst_en",    wclk_en,   0);
        chk("t6_rst_full",  full,      0);
        chk("t6_rst_gray",  wptr_gray, 0);
        chk("t6_rst_ready", req_ready, 2'b00);
        rptr_gray_sync = '0;
        tick();
        WRST = 1'b1;
        #1;
        chk("t6_ready", req_ready, 2'b01);
        tick();
        chk("t6_grant", grant_id, 0);
        chk("t6_waddr", waddr,    0);
        chk("t6_en",    wclk_en,  1);
        chk("t6_wdata", wdata,    8'h11);
        req_valid = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
